// File: rtl/wormhole_out_chan_scheduler_pkg.sv
// Shared definitions for the per-output wormhole scheduler: flit type codes,
// scheduler state encoding and small decode helpers.
package wormhole_out_chan_scheduler_pkg;

    localparam int FLIT_W = 2;

    typedef logic [FLIT_W-1:0] flit_id_t;

    localparam flit_id_t FLIT_BODY      = 2'b00;
    localparam flit_id_t FLIT_HEAD      = 2'b01;
    localparam flit_id_t FLIT_TAIL      = 2'b10;
    localparam flit_id_t FLIT_HEAD_TAIL = 2'b11;

    typedef enum logic {
        SCHED_IDLE   = 1'b0,
        SCHED_LOCKED = 1'b1
    } sched_state_e;

    // A flit that opens a worm (HEAD, or a single-flit HEAD_TAIL packet).
    function automatic logic is_head(input flit_id_t f);
        return (f == FLIT_HEAD) || (f == FLIT_HEAD_TAIL);
    endfunction

    // A flit that closes a worm (TAIL, or a single-flit HEAD_TAIL packet).
    function automatic logic is_tail(input flit_id_t f);
        return (f == FLIT_TAIL) || (f == FLIT_HEAD_TAIL);
    endfunction

    // Index width that stays at least 1 bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wormhole_out_chan_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first request at or above ptr
// (wrapping at N-1) wins. Produces a one-hot grant, its index and a valid flag.
module wormhole_out_chan_scheduler_rr_arbiter
    import wormhole_out_chan_scheduler_pkg::*;
#(
    parameter  int N  = 5,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Scan offsets from farthest to nearest so the nearest request overwrites.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt      = '0;
                gnt[j]   = 1'b1;
                gnt_idx  = IW'(j);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wormhole_out_chan_scheduler.sv
// Per-output-channel scheduler of a 2D-mesh wormhole node. Arbitrates HEAD
// requests round-robin, locks the output to the winning VC from HEAD to TAIL,
// drives the crossbar select / downstream write enable and runs a stall
// watchdog while locked.
//
// Handshake: while locked, the owning VC offers a flit with data_vld_i[owner];
// the downstream FIFO accepts with ochan_rdy_i. A flit moves (and the VC pops)
// exactly in a cycle where both are high, which is when out_vld_o is high.
module wormhole_out_chan_scheduler
    import wormhole_out_chan_scheduler_pkg::*;
#(
    parameter  int IN_N        = 5,
    parameter  int OUT_M       = 5,
    parameter  int FLIT_ID_W   = 2,
    parameter  int OUT_CHAN_ID = 0,
    parameter  int WDOG_W      = 4,
    localparam int RW          = idx_w(OUT_M),
    localparam int IW          = idx_w(IN_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N*RW-1:0]        rtr_res_i,
    input  logic [IN_N-1:0]           rtr_res_vld_i,
    input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
    input  logic [IN_N-1:0]           data_vld_i,
    input  logic                      ochan_rdy_i,
    output logic [IW-1:0]             sel_o,
    output logic                      out_vld_o,
    output logic [IN_N-1:0]           chan_alloc_o,
    output logic                      busy_o,
    output logic                      stall_o
);

    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    sched_state_e       state_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      ptr_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic [IN_N-1:0]    alloc_q;

    logic [IN_N-1:0]    req;
    logic [IN_N-1:0]    gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               locked;
    logic               xfer;
    flit_id_t           owner_fid;
    logic [IW-1:0]      ptr_next;

    // A VC requests this output only with a valid HEAD routed here.
    always_comb begin
        req = '0;
        for (int i = 0; i < IN_N; i++) begin
            req[i] = data_vld_i[i] & rtr_res_vld_i[i]
                   & (rtr_res_i[i*RW +: RW] == RW'(OUT_CHAN_ID))
                   & is_head(flit_id_t'(flit_id_i[i*FLIT_ID_W +: FLIT_W]));
        end
    end

    wormhole_out_chan_scheduler_rr_arbiter #(
        .N (IN_N)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign locked    = (state_q == SCHED_LOCKED);
    assign owner_fid = flit_id_t'(flit_id_i[int'(owner_q)*FLIT_ID_W +: FLIT_W]);
    assign xfer      = locked & data_vld_i[owner_q] & ochan_rdy_i;
    assign ptr_next  = (owner_q == IW'(IN_N - 1)) ? '0 : owner_q + 1'b1;

    assign sel_o        = locked ? owner_q : '0;
    assign out_vld_o    = xfer;
    assign chan_alloc_o = alloc_q;
    assign busy_o       = locked;
    assign stall_o      = locked & (wdog_q == WDOG_MAX);

    // Scheduler FSM: grant in IDLE, hold the lock until the owner's TAIL moves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCHED_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
            alloc_q <= '0;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    wdog_q <= '0;
                    if (gnt_vld) begin
                        state_q <= SCHED_LOCKED;
                        owner_q <= gnt_idx;
                        alloc_q <= gnt;
                    end
                end
                SCHED_LOCKED: begin
                    if (xfer) begin
                        wdog_q <= '0;
                        // Priority rotates only when a worm completes.
                        if (is_tail(owner_fid)) begin
                            state_q <= SCHED_IDLE;
                            alloc_q <= '0;
                            ptr_q   <= ptr_next;
                        end
                    end else if (wdog_q != WDOG_MAX) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SCHED_IDLE;
                    alloc_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wormhole_out_chan_scheduler.sv
// Directed bench for wormhole_out_chan_scheduler: a vector table for the
// single-VC and contention traffic, plus hand-written multi-cycle sequences.
module tb_wormhole_out_chan_scheduler;

    localparam int IN_N        = 5;
    localparam int OUT_M       = 5;
    localparam int FLIT_ID_W   = 2;
    localparam int OUT_CHAN_ID = 0;
    localparam int WDOG_W      = 2;
    localparam int RW          = 3;
    localparam int IW          = 3;

    // ---------------- clock / reset ----------------
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [IN_N*RW-1:0]        rtr_res_i;
    logic [IN_N-1:0]           rtr_res_vld_i;
    logic [IN_N*FLIT_ID_W-1:0] flit_id_i;
    logic [IN_N-1:0]           data_vld_i;
    logic                      ochan_rdy_i;
    logic [IW-1:0]             sel_o;
    logic                      out_vld_o;
    logic [IN_N-1:0]           chan_alloc_o;
    logic                      busy_o;
    logic                      stall_o;

    wormhole_out_chan_scheduler #(
        .IN_N        (IN_N),
        .OUT_M       (OUT_M),
        .FLIT_ID_W   (FLIT_ID_W),
        .OUT_CHAN_ID (OUT_CHAN_ID),
        .WDOG_W      (WDOG_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rtr_res_i     (rtr_res_i),
        .rtr_res_vld_i (rtr_res_vld_i),
        .flit_id_i     (flit_id_i),
        .data_vld_i    (data_vld_i),
        .ochan_rdy_i   (ochan_rdy_i),
        .sel_o         (sel_o),
        .out_vld_o     (out_vld_o),
        .chan_alloc_o  (chan_alloc_o),
        .busy_o        (busy_o),
        .stall_o       (stall_o)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic [4:0]  vld;
        logic [14:0] res;
        logic [9:0]  fid;
        logic        rdy;
        logic [2:0]  sel;
        logic        ovld;
        logic [4:0]  alloc;
        logic        busy;
        logic        stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string n, input logic [4:0] v, input logic [14:0] r,
                                input logic [9:0] f, input logic rdy, input logic [2:0] s,
                                input logic ov, input logic [4:0] a, input logic b,
                                input logic st);
        vec_t t;
        t.name = n; t.vld = v; t.res = r; t.fid = f; t.rdy = rdy;
        t.sel = s; t.ovld = ov; t.alloc = a; t.busy = b; t.stall = st;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] v, input logic [14:0] r, input logic [9:0] f,
                         input logic rdy);
        data_vld_i    = v;
        rtr_res_vld_i = v;
        rtr_res_i     = r;
        flit_id_i     = f;
        ochan_rdy_i   = rdy;
    endtask

    task automatic check(input string n, input logic [2:0] s, input logic ov,
                         input logic [4:0] a, input logic b, input logic st);
        logic [10:0] exp_v;
        logic [10:0] act_v;
        exp_v = {s, ov, a, b, st};
        act_v = {sel_o, out_vld_o, chan_alloc_o, busy_o, stall_o};
        checks++;
        if (act_v === exp_v) begin
            passes++;
        end else begin
            $display("FAIL %s: got sel=%0d vld=%b alloc=%b busy=%b stall=%b, expected sel=%0d vld=%b alloc=%b busy=%b stall=%b",
                     n, sel_o, out_vld_o, chan_alloc_o, busy_o, stall_o, s, ov, a, b, st);
        end
    endtask

    // One cycle: inputs applied just after posedge, outputs checked at negedge.
    task automatic cyc(input string n, input logic [4:0] v, input logic [14:0] r,
                       input logic [9:0] f, input logic rdy, input logic [2:0] s,
                       input logic ov, input logic [4:0] a, input logic b, input logic st);
        drive(v, r, f, rdy);
        @(negedge clk_i);
        check(n, s, ov, a, b, st);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        drive('0, '0, '0, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("reset_state", 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Contention from ptr=0: VC0, VC1, VC4 heads served 0, 1, 4.
        tbl.push_back(mk("c_idle",     5'b10011, 15'h0, 10'h105, 1, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("c_vc0_head", 5'b10011, 15'h0, 10'h105, 1, 0, 1, 5'b00001, 1, 0));
        tbl.push_back(mk("c_vc0_tail", 5'b10011, 15'h0, 10'h106, 1, 0, 1, 5'b00001, 1, 0));
        tbl.push_back(mk("c_gap1",     5'b10010, 15'h0, 10'h104, 1, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("c_vc1_head", 5'b10010, 15'h0, 10'h104, 1, 1, 1, 5'b00010, 1, 0));
        tbl.push_back(mk("c_vc1_tail", 5'b10010, 15'h0, 10'h108, 1, 1, 1, 5'b00010, 1, 0));
        tbl.push_back(mk("c_gap2",     5'b10000, 15'h0, 10'h100, 1, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("c_vc4_head", 5'b10000, 15'h0, 10'h100, 1, 4, 1, 5'b10000, 1, 0));
        tbl.push_back(mk("c_vc4_tail", 5'b10000, 15'h0, 10'h200, 1, 4, 1, 5'b10000, 1, 0));
        tbl.push_back(mk("c_done",     5'b00000, 15'h0, 10'h000, 1, 0, 0, 5'b00000, 0, 0));
        // Single VC2 worm HEAD, BODY, TAIL (ptr wrapped back to 0).
        tbl.push_back(mk("s_idle",     5'b00100, 15'h0, 10'h010, 1, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("s_head",     5'b00100, 15'h0, 10'h010, 1, 2, 1, 5'b00100, 1, 0));
        tbl.push_back(mk("s_body",     5'b00100, 15'h0, 10'h000, 1, 2, 1, 5'b00100, 1, 0));
        tbl.push_back(mk("s_tail",     5'b00100, 15'h0, 10'h020, 1, 2, 1, 5'b00100, 1, 0));
        tbl.push_back(mk("s_done",     5'b00000, 15'h0, 10'h000, 1, 0, 0, 5'b00000, 0, 0));
        // VC1 head routed to output 1 never requests here.
        tbl.push_back(mk("f_route",    5'b00010, 15'h0008, 10'h004, 1, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("f_no_grant", 5'b00010, 15'h0008, 10'h004, 1, 0, 0, 5'b00000, 0, 0));
        // ptr=3 after VC2: VC3 beats VC0.
        tbl.push_back(mk("p3_idle",    5'b01001, 15'h0, 10'h041, 0, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("p3_vc3_win", 5'b01001, 15'h0, 10'h041, 0, 3, 0, 5'b01000, 1, 0));
        tbl.push_back(mk("p3_vc3_tail",5'b01001, 15'h0, 10'h081, 1, 3, 1, 5'b01000, 1, 0));
        tbl.push_back(mk("p3_done",    5'b00000, 15'h0, 10'h000, 1, 0, 0, 5'b00000, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].name, tbl[i].vld, tbl[i].res, tbl[i].fid, tbl[i].rdy,
                tbl[i].sel, tbl[i].ovld, tbl[i].alloc, tbl[i].busy, tbl[i].stall);
        end

        // Backpressure mid-worm: owner held, no foreign grant, no lost flit.
        do_reset();
        cyc("bp_idle", 5'b00010, 15'h0, 10'h004, 1, 0, 0, 5'b00000, 0, 0);
        cyc("bp_head", 5'b00010, 15'h0, 10'h004, 1, 1, 1, 5'b00010, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("bp_hold%0d", i), 5'b01010, 15'h0, 10'h040, 0,
                1, 0, 5'b00010, 1, (i >= 3));
        end
        cyc("bp_resume", 5'b01010, 15'h0, 10'h040, 1, 1, 1, 5'b00010, 1, 1);
        cyc("bp_tail",   5'b01010, 15'h0, 10'h048, 1, 1, 1, 5'b00010, 1, 0);
        cyc("bp_gap",    5'b01000, 15'h0, 10'h040, 1, 0, 0, 5'b00000, 0, 0);
        cyc("bp_next",   5'b01000, 15'h0, 10'h040, 1, 3, 1, 5'b01000, 1, 0);

        // Watchdog: owner bubble, VC0 head waiting but never granted.
        do_reset();
        cyc("wd_idle", 5'b00100, 15'h0, 10'h010, 1, 0, 0, 5'b00000, 0, 0);
        cyc("wd_head", 5'b00100, 15'h0, 10'h010, 1, 2, 1, 5'b00100, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("wd_bubble%0d", i), 5'b00001, 15'h0, 10'h001, 1,
                2, 0, 5'b00100, 1, (i == 3));
        end
        cyc("wd_body",  5'b00101, 15'h0, 10'h001, 1, 2, 1, 5'b00100, 1, 1);
        cyc("wd_clear", 5'b00101, 15'h0, 10'h021, 1, 2, 1, 5'b00100, 1, 0);
        cyc("wd_idle2", 5'b00001, 15'h0, 10'h001, 1, 0, 0, 5'b00000, 0, 0);

        // HEAD_TAIL from VC3, then ptr=4 wraps so VC0 beats VC3.
        do_reset();
        cyc("ht_idle", 5'b01000, 15'h0, 10'h0C0, 1, 0, 0, 5'b00000, 0, 0);
        cyc("ht_xfer", 5'b01000, 15'h0, 10'h0C0, 1, 3, 1, 5'b01000, 1, 0);
        cyc("ht_gap",  5'b01001, 15'h0, 10'h041, 1, 0, 0, 5'b00000, 0, 0);
        cyc("ht_vc0",  5'b01001, 15'h0, 10'h041, 1, 0, 1, 5'b00001, 1, 0);

        // Reset mid-worm: outputs clear asynchronously, ptr returns to 0.
        do_reset();
        cyc("rm_idle", 5'b00010, 15'h0, 10'h004, 1, 0, 0, 5'b00000, 0, 0);
        cyc("rm_h1",   5'b00010, 15'h0, 10'h004, 1, 1, 1, 5'b00010, 1, 0);
        cyc("rm_t1",   5'b00010, 15'h0, 10'h008, 1, 1, 1, 5'b00010, 1, 0);
        cyc("rm_gap",  5'b01000, 15'h0, 10'h040, 1, 0, 0, 5'b00000, 0, 0);
        cyc("rm_h3",   5'b01000, 15'h0, 10'h040, 1, 3, 1, 5'b01000, 1, 0);
        cyc("rm_b3",   5'b01000, 15'h0, 10'h000, 1, 3, 1, 5'b01000, 1, 0);
        drive(5'b01000, 15'h0, 10'h080, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rm_async", 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0);
        drive('0, '0, '0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cyc("rm_after",      5'b00101, 15'h0, 10'h011, 1, 0, 0, 5'b00000, 0, 0);
        cyc("rm_after_gnt",  5'b00101, 15'h0, 10'h011, 1, 0, 1, 5'b00001, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
